// File: rtl/wavelet_pkg.sv
// wavelet_pkg: shared constants for the Ricker-wavelet filter bank.
// Optional build macro used by the scheduler: WAVELET_SCHED_DECIM_EN.
package wavelet_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CALC    = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] EMIT    = 2'd3;

  localparam int DEF_BITS_PER_ELEM  = 8;
  localparam int DEF_NUM_ELEM       = 9;
  localparam int DEF_NUM_FILTERS    = 4;
  localparam int DEF_SUM_TRUNCATION = 8;
  localparam int DEF_DECIM          = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wavelet_scheduler_if.sv
// wavelet_scheduler_if: sample, tap, fir and result signals of the scheduler.
// slave = scheduler side, master = source/fir/consumer side.
interface wavelet_scheduler_if import wavelet_pkg::*; #(
  parameter int BITS_PER_ELEM  = DEF_BITS_PER_ELEM,
  parameter int NUM_ELEM       = DEF_NUM_ELEM,
  parameter int NUM_FILTERS    = DEF_NUM_FILTERS,
  parameter int SUM_TRUNCATION = DEF_SUM_TRUNCATION
);

  localparam int IW = idx_w(NUM_FILTERS);

  logic signed [BITS_PER_ELEM-1:0]       i_sample;
  logic                                  i_sample_valid;
  logic                                  o_sample_ready;
  logic [NUM_ELEM*BITS_PER_ELEM-1:0]     o_taps;
  logic                                  o_start_calc;
  logic [NUM_FILTERS*SUM_TRUNCATION-1:0] i_wavelets;
  logic [SUM_TRUNCATION-1:0]             o_result;
  logic [IW-1:0]                         o_result_idx;
  logic                                  o_result_valid;
  logic                                  i_result_ready;
  logic                                  o_busy;

  modport slave (
    input  i_sample, i_sample_valid, i_wavelets, i_result_ready,
    output o_sample_ready, o_taps, o_start_calc,
    output o_result, o_result_idx, o_result_valid, o_busy
  );

  modport master (
    output i_sample, i_sample_valid, i_wavelets, i_result_ready,
    input  o_sample_ready, o_taps, o_start_calc,
    input  o_result, o_result_idx, o_result_valid, o_busy
  );

endinterface

// File: rtl/wavelet_scheduler_tap_delay_line.sv
// tap_delay_line: sample shift register, element 0 = newest,
// with a fill counter saturating at NUM_ELEM.
module tap_delay_line import wavelet_pkg::*; #(
  parameter int BITS_PER_ELEM = DEF_BITS_PER_ELEM,
  parameter int NUM_ELEM      = DEF_NUM_ELEM
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              shift_en,
  input  logic [BITS_PER_ELEM-1:0]          din,
  output logic [NUM_ELEM*BITS_PER_ELEM-1:0] taps,
  output logic                              primed
);

  localparam int FW = $clog2(NUM_ELEM + 1);
  localparam int TW = NUM_ELEM * BITS_PER_ELEM;

  logic [TW-1:0] r_taps;
  logic [FW-1:0] r_fill;

  // shift newest sample into element 0, count accepted samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_taps <= '0;
      r_fill <= '0;
    end else if (shift_en) begin
      r_taps <= {r_taps[TW-BITS_PER_ELEM-1:0], din};
      if (r_fill != FW'(NUM_ELEM))
        r_fill <= r_fill + 1'b1;
    end
  end

  assign taps   = r_taps;
  // line is full, or becomes full with the shift happening now
  assign primed = (r_fill == FW'(NUM_ELEM)) ||
                  (shift_en && (r_fill == FW'(NUM_ELEM - 1)));

endmodule

// File: rtl/wavelet_scheduler.sv
// wavelet_scheduler: feeds the fir bank and serialises its outputs.
// Build macro WAVELET_SCHED_DECIM_EN enables 1-in-DECIM calc gating.
module wavelet_scheduler import wavelet_pkg::*; #(
  parameter int BITS_PER_ELEM  = DEF_BITS_PER_ELEM,
  parameter int NUM_ELEM       = DEF_NUM_ELEM,
  parameter int NUM_FILTERS    = DEF_NUM_FILTERS,
  parameter int SUM_TRUNCATION = DEF_SUM_TRUNCATION,
  parameter int DECIM          = DEF_DECIM
) (
  input logic               clk,
  input logic               rst,
  wavelet_scheduler_if.slave bus
);

  localparam int IW = idx_w(NUM_FILTERS);

  logic [1:0]                r_state;
  logic [IW-1:0]             r_idx;
  logic [SUM_TRUNCATION-1:0] r_hold [NUM_FILTERS];

  logic w_accept;
  logic w_primed;
  logic w_gate;
  logic w_last;
  logic w_emit;

  assign w_accept = bus.i_sample_valid && bus.o_sample_ready;
  assign w_last   = (r_idx == IW'(NUM_FILTERS - 1));
  assign w_emit   = !rst && (r_state == EMIT);

  tap_delay_line #(
    .BITS_PER_ELEM (BITS_PER_ELEM),
    .NUM_ELEM      (NUM_ELEM)
  ) u_line (
    .clk      (clk),
    .rst      (rst),
    .shift_en (w_accept),
    .din      (bus.i_sample),
    .taps     (bus.o_taps),
    .primed   (w_primed)
  );

`ifdef WAVELET_SCHED_DECIM_EN
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [DW-1:0] r_dcnt;

  // mod-DECIM count of primed accepted samples
  always_ff @(posedge clk) begin
    if (rst)
      r_dcnt <= '0;
    else if (w_accept && w_primed)
      r_dcnt <= (r_dcnt >= DW'(DECIM - 1)) ? '0 : r_dcnt + 1'b1;
  end

  assign w_gate = (r_dcnt == '0);
`else
  if (DECIM < 1) begin : g_decim_unused
  end

  assign w_gate = 1'b1;
`endif

  // sequencing: accept -> calc pulse -> capture -> emit burst
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (w_accept && w_primed && w_gate)
            r_state <= CALC;
        CALC:
          r_state <= CAPTURE;
        CAPTURE: begin
          r_idx   <= '0;
          r_state <= EMIT;
        end
        EMIT:
          if (bus.i_result_ready) begin
            if (w_last)
              r_state <= IDLE;
            else
              r_idx <= r_idx + 1'b1;
          end
        default:
          r_state <= IDLE;
      endcase
    end
  end

  // snapshot every fir output one cycle after the calc pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_FILTERS; k++)
        r_hold[k] <= '0;
    end else if (r_state == CAPTURE) begin
      for (int k = 0; k < NUM_FILTERS; k++)
        r_hold[k] <= bus.i_wavelets[k*SUM_TRUNCATION +: SUM_TRUNCATION];
    end
  end

  assign bus.o_sample_ready = !rst && (r_state == IDLE);
  assign bus.o_start_calc   = !rst && (r_state == CALC);
  assign bus.o_busy         = !rst && (r_state != IDLE);
  assign bus.o_result_valid = w_emit;
  assign bus.o_result       = w_emit ? r_hold[r_idx] : '0;
  assign bus.o_result_idx   = w_emit ? r_idx : '0;

endmodule

// File: tb/tb_wavelet_scheduler.sv
// tb_wavelet_scheduler: directed + random checks against a timeline model.
// Honours WAVELET_SCHED_DECIM_EN the same way as the design.
module tb_wavelet_scheduler;
  import wavelet_pkg::*;

  localparam int B     = 8;
  localparam int N     = 9;
  localparam int NF    = 4;
  localparam int ST    = 8;
  localparam int DECIM = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wavelet_scheduler_if #(
    .BITS_PER_ELEM  (B),
    .NUM_ELEM       (N),
    .NUM_FILTERS    (NF),
    .SUM_TRUNCATION (ST)
  ) bus ();

  wavelet_scheduler #(
    .BITS_PER_ELEM  (B),
    .NUM_ELEM       (N),
    .NUM_FILTERS    (NF),
    .SUM_TRUNCATION (ST),
    .DECIM          (DECIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass = 0;
  int n_tot  = 0;

  function automatic void chk(input string name,
                              input logic [71:0] act,
                              input logic [71:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // model: newest-first sample history, burst timeline, result queue
  logic [7:0] hist[$];
  logic [7:0] res[$];
  int ph   = 0;
  int k    = 0;
  int dcnt = 0;
  bit en   = 0;

  int n_calc = 0;
  logic [7:0] got[$];

  function automatic logic [71:0] exp_taps();
    logic [71:0] t;
    t = '0;
    for (int i = 0; i < hist.size(); i++) t[i*8 +: 8] = hist[i];
    return t;
  endfunction

  always @(negedge clk) begin
    if (en) begin
      logic e_rdy, e_st, e_val, e_busy;
      logic [7:0] e_res;
      logic [1:0] e_idx;
      logic trig;
      e_rdy  = !rst && ph == 0;
      e_st   = !rst && ph == 1;
      e_val  = !rst && ph == 3;
      e_busy = !rst && ph != 0;
      e_res  = e_val ? res[0] : 8'h00;
      e_idx  = e_val ? 2'(k) : 2'd0;
      chk("sample_ready", bus.o_sample_ready, e_rdy);
      chk("start_calc", bus.o_start_calc, e_st);
      chk("result_valid", bus.o_result_valid, e_val);
      chk("busy", bus.o_busy, e_busy);
      chk("result", bus.o_result, e_res);
      chk("result_idx", bus.o_result_idx, e_idx);
      chk("taps", bus.o_taps, exp_taps());
      if (!rst && bus.o_start_calc) n_calc++;
      if (bus.o_result_valid && bus.i_result_ready)
        got.push_back(bus.o_result);
      if (rst) begin
        hist.delete();
        res.delete();
        ph = 0;
        k = 0;
        dcnt = 0;
      end else if (ph == 0) begin
        if (bus.i_sample_valid) begin
          hist.push_front(bus.i_sample);
          if (hist.size() > N) void'(hist.pop_back());
          if (hist.size() == N) begin
`ifdef WAVELET_SCHED_DECIM_EN
            trig = (dcnt == 0);
            dcnt = (dcnt + 1) % DECIM;
`else
            trig = 1'b1;
`endif
            if (trig) ph = 1;
          end
        end
      end else if (ph == 1) begin
        ph = 2;
      end else if (ph == 2) begin
        for (int j = 0; j < NF; j++)
          res.push_back(bus.i_wavelets[j*8 +: 8]);
        k = 0;
        ph = 3;
      end else begin
        if (bus.i_result_ready) begin
          void'(res.pop_front());
          k++;
          if (res.size() == 0) ph = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] s);
    int w;
    w = 0;
    bus.i_sample = s;
    bus.i_sample_valid = 1'b1;
    @(negedge clk);
    while (!bus.o_sample_ready && w < 60) begin
      w++;
      @(negedge clk);
    end
    if (w >= 60) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.i_sample_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic trigger(input logic [7:0] base);
    int c0, tries;
    c0 = n_calc;
    tries = 0;
    do begin
      send(base + 8'(tries));
      @(negedge clk);
      tries++;
      tick();
    end while (n_calc == c0 && tries < 4);
    if (n_calc == c0) chk("trigger_timeout", 1, 0);
  endtask

  task automatic wait_valid_idx(input int idx);
    int w;
    w = 0;
    @(negedge clk);
    while (!(bus.o_result_valid && bus.o_result_idx == 2'(idx)) && w < 40) begin
      w++;
      @(negedge clk);
    end
    if (w >= 40) chk("wait_valid_timeout", 1, 0);
  endtask

  initial begin
    int c0;
    logic e;
    bus.i_sample = '0;
    bus.i_sample_valid = 1'b0;
    bus.i_wavelets = '0;
    bus.i_result_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    en = 1;
    @(negedge clk);
    chk("rst_ready", bus.o_sample_ready, 0);
    chk("rst_taps", bus.o_taps, 0);
    chk("rst_valid", bus.o_result_valid, 0);
    tick();
    rst = 1'b0;
    bus.i_wavelets = 32'h44332211;
    bus.i_result_ready = 1'b1;

    for (int s = 1; s <= 8; s++) send(8'(s));
    @(negedge clk);
    chk("prime_no_calc", n_calc, 0);
    tick();
    send(8'd9);
    @(negedge clk);
    chk("prime_start_t1", bus.o_start_calc, 1);
    chk("prime_taps", bus.o_taps, 72'h010203040506070809);
    @(negedge clk);
    chk("capture_no_valid", bus.o_result_valid, 0);
    for (int j = 0; j < NF; j++) begin
      @(negedge clk);
      chk("ser_valid", bus.o_result_valid, 1);
      chk("ser_result", bus.o_result, 72'(8'h11 * (j + 1)));
      chk("ser_idx", bus.o_result_idx, 72'(j));
    end
    @(negedge clk);
    chk("ready_back_t7", bus.o_sample_ready, 1);
    chk("ser_count", got.size(), 4);
    if (got.size() == 4)
      for (int j = 0; j < 4; j++) chk("ser_order", got[j], 72'(8'h11 * (j + 1)));
    got.delete();
    tick();

    bus.i_result_ready = 1'b0;
    trigger(8'd10);
    wait_valid_idx(0);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      chk("bp_result", bus.o_result, 8'h11);
      chk("bp_idx", bus.o_result_idx, 0);
      chk("bp_ready", bus.o_sample_ready, 0);
    end
    tick();
    bus.i_result_ready = 1'b1;
    c0 = 0;
    @(negedge clk);
    while (bus.o_result_valid && c0 < 20) begin
      c0++;
      @(negedge clk);
    end
    chk("bp_count", got.size(), 4);
    if (got.size() == 4)
      for (int j = 0; j < 4; j++) chk("bp_order", got[j], 72'(8'h11 * (j + 1)));
    got.delete();
    tick();

    bus.i_wavelets = 32'hD4C3B2A1;
    trigger(8'd20);
    wait_valid_idx(1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", bus.o_result_valid, 0);
    chk("mid_rst_busy", bus.o_busy, 0);
    chk("mid_rst_taps", bus.o_taps, 0);
    chk("mid_rst_got", got.size(), 2);
    tick();
    c0 = n_calc;
    for (int s = 1; s <= 8; s++) send(8'(s + 40));
    @(negedge clk);
    chk("mid_rst_reprime", n_calc - c0, 0);
    tick();

    pulse_rst();
    for (int s = 1; s <= 12; s++) begin
      send(8'(s));
      @(negedge clk);
`ifdef WAVELET_SCHED_DECIM_EN
      e = (s >= 9) && ((s - 9) % DECIM == 0);
`else
      e = (s >= 9);
`endif
      chk("decim_calc", bus.o_start_calc, e);
      tick();
    end

    pulse_rst();
    for (int i = 0; i < 10; i++) begin
      bus.i_sample_valid = (i % 2 == 0);
      bus.i_sample = 8'(8'hA1 + i / 2);
      tick();
    end
    bus.i_sample_valid = 1'b0;
    @(negedge clk);
    chk("throttle_taps", bus.o_taps, 72'h00000000A1A2A3A4A5);
    tick();

    for (int i = 0; i < 3000; i++) begin
      bus.i_sample_valid = ($urandom % 3) != 0;
      bus.i_sample = 8'($urandom);
      bus.i_result_ready = ($urandom % 4) != 0;
      bus.i_wavelets = 32'($urandom);
      rst = ($urandom % 200) == 0;
      tick();
    end
    rst = 1'b0;
    bus.i_sample_valid = 1'b0;
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
